// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive framing controller.
package uart_pkg;

  localparam int OVERSAMPLE = 16;

  localparam logic [7:0] SYNC0_DEFAULT = 8'hAA;
  localparam logic [7:0] SYNC1_DEFAULT = 8'h55;

  typedef enum logic [2:0] {
    ST_HUNT0,
    ST_HUNT1,
    ST_LEN,
    ST_PAYLOAD,
    ST_CSUM
  } state_e;

  typedef enum logic [2:0] {
    ERR_OK      = 3'd0,
    ERR_LEN     = 3'd1,
    ERR_CSUM    = 3'd2,
    ERR_TIMEOUT = 3'd3,
    ERR_OVERRUN = 3'd4
  } err_e;

endpackage

// File: rtl/uart_tick_gen.sv
// Free-running sample tick divider; a new divisor only takes effect at the
// start of a period, so a period in progress always completes unchanged.
module uart_tick_gen #(
  parameter int DIV_W = 16
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic [DIV_W-1:0] divisor_in,
  output logic             tick_out
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] period;
  logic             tick_q, tick_d;

  // Count 0 marks the first cycle of a period, where the divisor is captured.
  always_comb begin
    period = (cnt_q == '0) ? divisor_in : div_q;
    div_d  = period;
    tick_d = (period <= DIV_W'(1)) || (cnt_q == period - DIV_W'(1));
    cnt_d  = tick_d ? '0 : cnt_q + DIV_W'(1);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cnt_q  <= '0;
      div_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      tick_q <= tick_d;
    end
  end

  assign tick_out = tick_q;

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// Receive-path sequencer: paces the byte receiver, parses sync/len/payload/xor
// frames, forwards payload over valid/ready and reports per-frame status.
module uart_rx_frame_ctrl
  import uart_pkg::*;
#(
  parameter int         DIV_W         = 16,
  parameter int         MAX_LEN       = 64,
  parameter logic [7:0] SYNC0         = SYNC0_DEFAULT,
  parameter logic [7:0] SYNC1         = SYNC1_DEFAULT,
  parameter int         TIMEOUT_BYTES = 32
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic [DIV_W-1:0] divisor_in,
  output logic             sample_tick_out,
  input  logic             byte_valid_in,
  input  logic [7:0]       byte_in,
  output logic [7:0]       pkt_data_out,
  output logic             pkt_valid_out,
  output logic             pkt_last_out,
  input  logic             pkt_ready_in,
  output logic             frame_done_out,
  output logic [2:0]       frame_err_out,
  output logic             busy_out
);

  localparam int             TO_LIMIT  = OVERSAMPLE * TIMEOUT_BYTES;
  localparam int             TO_W      = $clog2(TO_LIMIT) + 1;
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TO_LIMIT - 1);
  localparam logic [7:0]     MAX_LEN_B = 8'(MAX_LEN);

  state_e          state_q, state_d;
  err_e            err_q, err_d;
  logic [7:0]      csum_q, csum_d;
  logic [7:0]      remaining_q, remaining_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            last_q, last_d;
  logic            done_q, done_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            tick;

  uart_tick_gen #(.DIV_W(DIV_W)) u_tick_gen (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .divisor_in(divisor_in),
    .tick_out  (tick)
  );

  always_comb begin
    state_d     = state_q;
    err_d       = ERR_OK;
    done_d      = 1'b0;
    csum_d      = csum_q;
    remaining_d = remaining_q;
    data_d      = data_q;
    valid_d     = valid_q;
    last_d      = last_q;
    to_cnt_d    = to_cnt_q;

    if (valid_q && pkt_ready_in) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end

    if (state_q == ST_HUNT0 || byte_valid_in) begin
      to_cnt_d = '0;
    end else if (tick) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end

    // A byte always takes priority over a timeout landing on the same tick.
    if (byte_valid_in) begin
      case (state_q)
        ST_HUNT0: if (byte_in == SYNC0) state_d = ST_HUNT1;
        ST_HUNT1: begin
          if (byte_in == SYNC1) state_d = ST_LEN;
          else if (byte_in != SYNC0) state_d = ST_HUNT0;
        end
        ST_LEN: begin
          if (byte_in == 8'd0 || byte_in > MAX_LEN_B) begin
            done_d  = 1'b1;
            err_d   = ERR_LEN;
            state_d = ST_HUNT0;
          end else begin
            csum_d      = byte_in;
            remaining_d = byte_in;
            state_d     = ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          if (valid_q && !pkt_ready_in) begin
            done_d  = 1'b1;
            err_d   = ERR_OVERRUN;
            state_d = ST_HUNT0;
          end else begin
            data_d      = byte_in;
            valid_d     = 1'b1;
            last_d      = (remaining_q == 8'd1);
            csum_d      = csum_q ^ byte_in;
            remaining_d = remaining_q - 8'd1;
            if (remaining_q == 8'd1) state_d = ST_CSUM;
          end
        end
        ST_CSUM: begin
          done_d  = 1'b1;
          err_d   = (byte_in == csum_q) ? ERR_OK : ERR_CSUM;
          state_d = ST_HUNT0;
        end
        default: state_d = ST_HUNT0;
      endcase
    end else if (state_q != ST_HUNT0 && tick && to_cnt_q == TO_LAST) begin
      done_d  = 1'b1;
      err_d   = ERR_TIMEOUT;
      state_d = ST_HUNT0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= ST_HUNT0;
      err_q       <= ERR_OK;
      done_q      <= 1'b0;
      csum_q      <= '0;
      remaining_q <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      to_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      err_q       <= err_d;
      done_q      <= done_d;
      csum_q      <= csum_d;
      remaining_q <= remaining_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      last_q      <= last_d;
      to_cnt_q    <= to_cnt_d;
    end
  end

  assign sample_tick_out = tick;
  assign pkt_data_out    = data_q;
  assign pkt_valid_out   = valid_q;
  assign pkt_last_out    = last_q;
  assign frame_done_out  = done_q;
  assign frame_err_out   = err_q;
  assign busy_out        = (state_q != ST_HUNT0);

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Scoreboard bench for uart_rx_frame_ctrl: frames are built at byte level,
// expectations queued at build time, and a monitor checks what comes out.
module tb_uart_rx_frame_ctrl;

  localparam logic [7:0] SYNC0 = 8'hAA;
  localparam logic [7:0] SYNC1 = 8'h55;
  localparam int MAX_LEN = 64;

  logic        clk = 1'b0;
  logic        rstN;
  logic [15:0] divisor;
  logic        sampleTick;
  logic        byteValid;
  logic [7:0]  byteData;
  logic [7:0]  pktData;
  logic        pktValid;
  logic        pktLast;
  logic        pktReady;
  logic        frameDone;
  logic [2:0]  frameErr;
  logic        busy;

  int checkCount = 0;
  int passCount = 0;
  bit randomReady = 1'b0;
  int lowRun = 0;

  logic [8:0] expData[$];
  logic [2:0] expErr[$];
  logic [7:0] txQ[$];

  uart_rx_frame_ctrl #(
    .DIV_W(16), .MAX_LEN(MAX_LEN), .SYNC0(SYNC0), .SYNC1(SYNC1), .TIMEOUT_BYTES(2)
  ) dut (
    .clk_in         (clk),
    .rst_n_in       (rstN),
    .divisor_in     (divisor),
    .sample_tick_out(sampleTick),
    .byte_valid_in  (byteValid),
    .byte_in        (byteData),
    .pkt_data_out   (pktData),
    .pkt_valid_out  (pktValid),
    .pkt_last_out   (pktLast),
    .pkt_ready_in   (pktReady),
    .frame_done_out (frameDone),
    .frame_err_out  (frameErr),
    .busy_out       (busy)
  );

  always #5 clk = ~clk;

  // Compare one observed value against the bench's own expectation.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
  endtask

  // Record an output event that had no expectation waiting for it.
  task automatic unexpectedEvent(input string name, input logic [31:0] actual);
    checkCount++;
    $display("[TB] FAIL %s: actual=%0h required=none", name, actual);
  endtask

  // Drive one receiver strobe, then idle for gap cycles; called just after a posedge.
  task automatic applyStimulus(input logic [7:0] b, input int gap);
    byteValid = 1'b1;
    byteData  = b;
    @(posedge clk);
    #1 byteValid = 1'b0;
    repeat (gap) @(posedge clk);
    #1;
  endtask

  task automatic sendTx(input int minGap, input int maxGap);
    while (txQ.size() != 0) applyStimulus(txQ.pop_front(), $urandom_range(minGap, maxGap));
  endtask

  // Frame model: payload is forwarded in order; status follows from the checksum.
  task automatic buildFrame(input int len, input logic [7:0] corrupt);
    logic [7:0] csum;
    logic [7:0] b;
    csum = 8'(len);
    txQ.push_back(SYNC0);
    txQ.push_back(SYNC1);
    txQ.push_back(8'(len));
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom_range(0, 255));
      csum ^= b;
      txQ.push_back(b);
      expData.push_back({(i == len - 1), b});
    end
    txQ.push_back(csum ^ corrupt);
    expErr.push_back(corrupt == 8'h00 ? 3'd0 : 3'd2);
  endtask

  task automatic pushBytes(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    txQ.push_back(a);
    txQ.push_back(b);
    txQ.push_back(c);
  endtask

  // Ready source that never stalls for more than two consecutive cycles.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (randomReady) begin
        if (lowRun >= 2 || $urandom_range(0, 1) == 1) begin
          pktReady = 1'b1;
          lowRun = 0;
        end else begin
          pktReady = 1'b0;
          lowRun++;
        end
      end else begin
        lowRun = 0;
      end
    end
  end

  // Monitor: pop and compare whenever the DUT hands over a byte or a status.
  always @(negedge clk) begin
    if (pktValid && pktReady) begin
      if (expData.size() == 0) unexpectedEvent("payload_extra", {23'd0, pktLast, pktData});
      else checkOutput("payload", {23'd0, pktLast, pktData}, {23'd0, expData.pop_front()});
    end
    if (frameDone) begin
      if (expErr.size() == 0) unexpectedEvent("status_extra", {29'd0, frameErr});
      else checkOutput("frame_err", {29'd0, frameErr}, {29'd0, expErr.pop_front()});
    end
  end

  initial begin
    int n;
    int len;
    int kind;
    logic [7:0] b;

    rstN = 1'b0;
    divisor = 16'd4;
    byteValid = 1'b0;
    byteData = 8'h00;
    pktReady = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_tick", {31'd0, sampleTick}, 0);
    checkOutput("reset_valid", {31'd0, pktValid}, 0);
    checkOutput("reset_last", {31'd0, pktLast}, 0);
    checkOutput("reset_data", {24'd0, pktData}, 0);
    checkOutput("reset_done", {31'd0, frameDone}, 0);
    checkOutput("reset_err", {29'd0, frameErr}, 0);
    checkOutput("reset_busy", {31'd0, busy}, 0);

    // Tick period 4, then a divisor change mid-period that only applies after the wrap.
    rstN = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("tick_edge%0d", k), {31'd0, sampleTick},
                  (k <= 8) ? ((k % 4) == 0) : ((k % 2) == 0));
      if (k == 5) divisor = 16'd2;
    end

    divisor = 16'd16;
    pktReady = 1'b1;
    repeat (20) @(posedge clk);
    #1;

    txQ = '{8'hAA, 8'h55, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
    expData.push_back({1'b0, 8'h11});
    expData.push_back({1'b0, 8'h22});
    expData.push_back({1'b1, 8'h33});
    expErr.push_back(3'd0);
    sendTx(2, 3);

    txQ = '{8'hAA, 8'h55, 8'h03, 8'h11, 8'h22, 8'h33, 8'h04};
    expData.push_back({1'b0, 8'h11});
    expData.push_back({1'b0, 8'h22});
    expData.push_back({1'b1, 8'h33});
    expErr.push_back(3'd2);
    sendTx(2, 3);

    pushBytes(8'hAA, 8'h55, 8'h00);
    expErr.push_back(3'd1);
    sendTx(2, 3);
    pushBytes(8'hAA, 8'h55, 8'h41);
    expErr.push_back(3'd1);
    sendTx(2, 3);

    txQ = '{8'hAA, 8'hAA, 8'h55, 8'h01, 8'h7E, 8'h7F};
    expData.push_back({1'b1, 8'h7E});
    expErr.push_back(3'd0);
    sendTx(2, 3);
    txQ = '{8'hAA, 8'h12, 8'hAA, 8'h55, 8'h01, 8'h7E, 8'h7F};
    expData.push_back({1'b1, 8'h7E});
    expErr.push_back(3'd0);
    sendTx(2, 3);

    // Backpressure: the held byte survives an overrun and is delivered later.
    pktReady = 1'b0;
    txQ = '{8'hAA, 8'h55, 8'h02, 8'h10, 8'h20};
    expData.push_back({1'b0, 8'h10});
    expErr.push_back(3'd4);
    sendTx(2, 2);
    repeat (3) begin
      checkOutput("held_valid", {31'd0, pktValid}, 1);
      checkOutput("held_data", {24'd0, pktData}, 32'h10);
      @(posedge clk);
      #1;
    end
    checkOutput("overrun_busy", {31'd0, busy}, 0);
    pktReady = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("released_valid", {31'd0, pktValid}, 0);

    // Randomized frames with junk prefixes, bad lengths, corrupt checksums, random ready.
    randomReady = 1'b1;
    for (int f = 0; f < 30; f++) begin
      repeat ($urandom_range(0, 3)) begin
        b = 8'($urandom_range(0, 255));
        if (b == SYNC0) b = 8'h00;
        txQ.push_back(b);
      end
      if ($urandom_range(0, 3) == 0) txQ.push_back(SYNC0);
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        len = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(MAX_LEN + 1, 255);
        pushBytes(SYNC0, SYNC1, 8'(len));
        expErr.push_back(3'd1);
      end else begin
        len = (kind == 3) ? MAX_LEN : $urandom_range(1, 10);
        buildFrame(len, (kind <= 2) ? 8'($urandom_range(1, 255)) : 8'h00);
      end
      sendTx(2, 5);
    end
    for (int i = 0; i < 200 && (expData.size() != 0 || expErr.size() != 0); i++) @(posedge clk);
    #1;
    randomReady = 1'b0;
    pktReady = 1'b1;

    // Timeout: TIMEOUT_BYTES=2 and divisor 1 give a 32-tick limit.
    divisor = 16'd1;
    repeat (40) @(posedge clk);
    #1;
    expData.push_back({1'b0, 8'h11});
    expErr.push_back(3'd3);
    pushBytes(8'hAA, 8'h55, 8'h03);
    sendTx(2, 2);
    applyStimulus(8'h11, 0);
    n = 0;
    for (int i = 1; i <= 40 && n == 0; i++) begin
      @(posedge clk);
      #1;
      if (frameDone) n = i;
    end
    checkOutput("timeout_latency", n, 32);
    repeat (3) @(posedge clk);
    #1;

    // A byte landing on the terminal tick keeps the frame alive.
    expData.push_back({1'b1, 8'h7E});
    expErr.push_back(3'd0);
    pushBytes(8'hAA, 8'h55, 8'h01);
    sendTx(2, 2);
    applyStimulus(8'h7E, 0);
    repeat (31) @(posedge clk);
    #1;
    applyStimulus(8'h7F, 40);

    // Asynchronous reset mid-frame drops everything at once.
    pktReady = 1'b0;
    txQ = '{8'hAA, 8'h55, 8'h03, 8'h11};
    sendTx(2, 2);
    checkOutput("prereset_valid", {31'd0, pktValid}, 1);
    #2 rstN = 1'b0;
    #1;
    checkOutput("async_valid", {31'd0, pktValid}, 0);
    checkOutput("async_busy", {31'd0, busy}, 0);
    @(posedge clk);
    #1 rstN = 1'b1;
    pktReady = 1'b1;
    pushBytes(8'h22, 8'h33, 8'h03);
    sendTx(2, 2);
    checkOutput("post_reset_busy", {31'd0, busy}, 0);
    txQ = '{8'hAA, 8'h55, 8'h01, 8'h5A, 8'h5B};
    expData.push_back({1'b1, 8'h5A});
    expErr.push_back(3'd0);
    sendTx(2, 2);

    for (int i = 0; i < 500 && (expData.size() != 0 || expErr.size() != 0); i++) @(posedge clk);
    #1;
    checkOutput("queues_drained", expData.size() + expErr.size(), 0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame_ctrl.md
# uart_rx_frame_ctrl

Sequencing controller for the UART receive path. Generates the 16x-oversample `sample_tick` that paces the byte receiver and consumes its one-cycle byte strobes. Parses the byte stream into framed packets: sync word, length, payload, XOR checksum. Forwards payload bytes downstream over a valid/ready handshake and reports per-frame status to the decoder pipeline.

## Interface
- `DIV_W`, 16: width of the tick divisor.
- `MAX_LEN`, 64: largest legal payload length in bytes; range 1..255.
- `SYNC0`, 8'hAA: first sync byte.
- `SYNC1`, 8'h55: second sync byte.
- `TIMEOUT_BYTES`, 32: inter-byte timeout, in byte times (one byte time = 16 sample ticks).

Ports:
- `clk_in` in 1: single clock.
- `rst_n_in` in 1: asynchronous, active-low reset.
- `divisor_in` in DIV_W: clock cycles per sample tick.
- `sample_tick_out` out 1: one-cycle pulse to the receiver.
- `byte_valid_in` in 1: one-cycle strobe from the receiver.
- `byte_in` in 8: received byte, valid with the strobe.
- `pkt_data_out` out 8: payload byte.
- `pkt_valid_out` out 1: payload byte valid.
- `pkt_last_out` out 1: final payload byte of the frame.
- `pkt_ready_in` in 1: downstream accepts the byte.
- `frame_done_out` out 1: one-cycle frame-end pulse.
- `frame_err_out` out 3: status code, valid with `frame_done_out`. 0=OK, 1=LEN, 2=CSUM, 3=TIMEOUT, 4=OVERRUN.
- `busy_out` out 1: high whenever state is not HUNT0.

## Operation
- **Tick generator:**
  - Counter runs 0..divisor-1. Tick fires when count == divisor-1, then the counter wraps to 0.
  - Divisor 0 or 1 gives a tick every cycle.
  - A new divisor is sampled only at wrap. The period in progress completes unchanged.
- **Parser FSM:** states HUNT0, HUNT1, LEN, PAYLOAD, CSUM. Transitions occur only on `byte_valid_in`.
  - HUNT0: byte==SYNC0 goes to HUNT1. Any other byte stays in HUNT0, with no error reported.
  - HUNT1: byte==SYNC1 goes to LEN. byte==SYNC0 stays in HUNT1. Any other byte goes to HUNT0 with no error reported.
  - LEN: a byte of 0 or >MAX_LEN raises error LEN and returns to HUNT0. Otherwise the byte is latched as `len`, the checksum is set to `len`, `remaining` is set to `len`, and the FSM goes to PAYLOAD.
  - PAYLOAD: each byte is loaded into the output register and XORed into the checksum, and `remaining` is decremented. When `remaining` reaches 0 the FSM goes to CSUM; `pkt_last_out` is set with that byte.
  - CSUM: byte == checksum gives done with OK; otherwise error CSUM. Either way the FSM returns to HUNT0.
- **Checksum arithmetic:** 8-bit XOR of the length byte and all payload bytes. The sync bytes are excluded.
- **Timeout:**
  - A counter of width ceil(log2(16*TIMEOUT_BYTES))+1 clears on every `byte_valid_in` and whenever the FSM is in HUNT0.
  - It increments on each sample tick in any other state.
  - Reaching 16*TIMEOUT_BYTES raises error TIMEOUT and returns the FSM to HUNT0.
- **Overrun:** in PAYLOAD, if `byte_valid_in` arrives while `pkt_valid_out && !pkt_ready_in`:
  - error OVERRUN is raised and the FSM returns to HUNT0;
  - the new byte is dropped, and the held byte stays presented until accepted.
- **Abort:** any error abort pulses `frame_done_out` with the error code. A payload byte already presented is never retracted. The consumer uses the error code to discard the partial frame.

## Timing
- **Reset values:** all outputs 0, FSM in HUNT0, tick counter 0, output register empty.
- **Asynchronous reset mid-frame:** `pkt_valid_out` and all other outputs drop immediately. The next frame must start from SYNC0.
- **Sample tick:** first pulse occurs `divisor` cycles after reset deasserts.
- **Payload output:**
  - A byte appears on `pkt_data_out`/`pkt_valid_out` the cycle after its `byte_valid_in`.
  - It is held stable until the cycle `pkt_valid_out && pkt_ready_in`, after which `pkt_valid_out` falls unless a new byte loads in the same cycle.
  - A byte arriving in the same cycle as the accept of the held byte is not an overrun; the register reloads.
- **Frame status:** `frame_done_out` pulses the cycle after the checksum byte, or the cycle after the error condition. `frame_err_out` is valid only during that pulse and is 0 otherwise.
- **Simultaneous byte and timeout terminal tick:** the byte wins and the counter clears.
- **Independence of the tick generator:** it free-runs in every FSM state and is unaffected by errors.

## Structure
- Package `uart_pkg` holds:
  - the FSM state enum;
  - the error-code enum (3-bit, values 0..4);
  - default SYNC0/SYNC1 constants;
  - the OVERSAMPLE=16 constant.
- One sub-module, `uart_tick_gen`, contains the divisor counter (inputs `clk_in`, `rst_n_in`, `divisor_in`; output tick). The parser, checksum, timeout and output register stay in the top level.

## Test plan
- **Tick generator:** divisor=4. `sample_tick_out` pulses on cycles 4, 8, 12 after reset. Switch to 2 mid-period; the current period still completes at 4 cycles, then the period is 2.
- **Good frame:** bytes AA 55 03 11 22 33 03 with `pkt_ready_in` high. Output is 11, 22, 33, with `pkt_last_out` on 33. `frame_done_out` pulses with err=0.
- **Checksum and length errors:**
  - the same frame with checksum 04 gives err=2;
  - AA 55 00 gives err=1;
  - AA 55 41 with MAX_LEN=64 gives err=1, with no payload output.
- **Sync recovery:**
  - AA AA 55 01 7E 7F yields payload 7E and OK status;
  - AA 12 AA 55 01 7E 7F also yields 7E OK, with no error reported for the 12.
- **Backpressure:** `pkt_ready_in` low, frame AA 55 02 10 20. Byte 10 is held, and byte 20 produces err=4. Byte 10 remains valid until `pkt_ready_in` rises.
- **Timeout:**
  - TIMEOUT_BYTES=2, divisor=1. After AA 55 03 11, with no further bytes, err=3 occurs after 32 ticks.
  - A byte landing on tick 32 instead keeps the frame alive.
